// File: rtl/sma_interp_x4_pkg.sv
// Shared types and widths for the linear-interpolating x4 upsampler.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents:
//   DATA_W_DEF / RATIO_LOG2_DEF : default sample width and log2 interpolation ratio
//   state_e                     : WAIT (idle, waiting for an input) / EMIT (producing a window)
//   DIFF_W / PROD_W             : derived widths for the default parameters
//   diff_w() / prod_w()         : the same derivations for arbitrary parameters
package sma_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int RATIO_LOG2_DEF = 2;

  // cur - prev needs one extra bit; multiplying by k (< RATIO) adds RATIO_LOG2 more.
  localparam int DIFF_W = DATA_W_DEF + 1;
  localparam int PROD_W = DATA_W_DEF + 1 + RATIO_LOG2_DEF;

  typedef enum logic {
    WAIT = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic int diff_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int prod_w(input int data_w, input int ratio_log2);
    return data_w + 1 + ratio_log2;
  endfunction

endpackage

// File: rtl/sma_interp_x4_if.sv
// Input/output sample streams of the interpolator, bundled as one interface.
// Latency: n/a (wiring only).
// Backpressure: x_valid/x_ready on the input side, y_valid/y_ready on the output side.
//
// Signals:
//   x, x_valid  -> into the block    x_ready -> back to the producer
//   y, y_valid  -> out of the block  y_ready -> back from the consumer
// Modports:
//   slave  : the interpolator's view
//   master : the surrounding environment's view (drives x/x_valid/y_ready)
interface sma_interp_x4_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] x;
  logic                     x_valid;
  logic                     x_ready;
  logic signed [DATA_W-1:0] y;
  logic                     y_valid;
  logic                     y_ready;

  modport slave (
    input  x, x_valid, y_ready,
    output x_ready, y, y_valid
  );

  modport master (
    output x, x_valid, y_ready,
    input  x_ready, y, y_valid
  );
endinterface

// File: rtl/sma_interp_x4_lerp.sv
// Linear interpolation point between two samples: y = prev + floor((cur - prev) * k / RATIO).
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports:
//   prev, cur : window end points, signed DATA_W
//   k         : phase within the window, unsigned RATIO_LOG2
//   y         : interpolated sample, signed DATA_W
module interp_lerp
  import sma_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RATIO_LOG2 = RATIO_LOG2_DEF
) (
  input  logic signed [DATA_W-1:0]     prev,
  input  logic signed [DATA_W-1:0]     cur,
  input  logic        [RATIO_LOG2-1:0] k,
  output logic signed [DATA_W-1:0]     y
);

  localparam int DW = diff_w(DATA_W);
  localparam int PW = prod_w(DATA_W, RATIO_LOG2);

  logic signed [DW-1:0] d;
  logic signed [PW-1:0] d_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] q;

  always_comb begin
    // Explicit sign extension keeps the full difference range (e.g. 32767 - -32768).
    d     = {cur[DATA_W-1], cur} - {prev[DATA_W-1], prev};
    d_ext = {{(PW-DW){d[DW-1]}}, d};
    k_ext = {{(PW-RATIO_LOG2){1'b0}}, k};
    p     = d_ext * k_ext;
    // Arithmetic shift floors toward -inf, so negative ramps round down, not toward zero.
    q     = p >>> RATIO_LOG2;
    // The true result lies between prev and cur, so dropping the upper bits is exact.
    y     = prev + q[DATA_W-1:0];
  end

endmodule

// File: rtl/sma_interp_x4.sv
// Linear-interpolating upsampler: RATIO outputs per input, ramping from the previous input to the current one.
// Latency: an accepted sample appears as the k=0 output of the window after its own, RATIO output transfers later.
// Backpressure: y_ready stalls the window in place; x_ready is only raised while idle or on the last phase with y_ready.
//
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous, active-low reset
//   bus  : sma_interp_x4_if.slave (x/x_valid/x_ready in, y/y_valid/y_ready out)
module sma_interp_x4
  import sma_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RATIO_LOG2 = RATIO_LOG2_DEF
) (
  input  logic           clk,
  input  logic           rst,
  sma_interp_x4_if.slave bus
);

  localparam logic [RATIO_LOG2-1:0] K_LAST = '1;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic [RATIO_LOG2-1:0]    k_q, k_d;

  logic                     x_xfer;
  logic signed [DATA_W-1:0] y_lerp;

  // State register: reset drops any partial window immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      prev_q  <= '0;
      cur_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      k_q     <= k_d;
    end
  end

  assign x_xfer = bus.x_valid && bus.x_ready;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    k_d     = k_q;
    unique case (state_q)
      WAIT: begin
        if (x_xfer) begin
          prev_d  = cur_q;
          cur_d   = bus.x;
          k_d     = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.y_ready) begin
          if (k_q != K_LAST) begin
            k_d = k_q + 1'b1;
          end else if (x_xfer) begin
            // Back-to-back: next window starts without a bubble.
            prev_d = cur_q;
            cur_d  = bus.x;
            k_d    = '0;
          end else begin
            // Starved: keep prev/cur so the next window starts from the old cur.
            state_d = WAIT;
          end
        end
      end
      default: state_d = WAIT;
    endcase
  end

  interp_lerp #(
    .DATA_W    (DATA_W),
    .RATIO_LOG2(RATIO_LOG2)
  ) u_lerp (
    .prev(prev_q),
    .cur (cur_q),
    .k   (k_q),
    .y   (y_lerp)
  );

  // Output logic. x_ready looks at y_ready so the next sample can land on the
  // same edge as the last output of the current window.
  always_comb begin
    bus.y       = y_lerp;
    bus.y_valid = (state_q == EMIT);
    bus.x_ready = (state_q == WAIT) ||
                  ((state_q == EMIT) && (k_q == K_LAST) && bus.y_ready);
  end

endmodule

// File: tb/tb_sma_interp_x4.sv
module tb_sma_interp_x4;

  localparam int DW  = 16;
  localparam int RL2 = 2;
  localparam int RAT = 1 << RL2;

  logic clk;
  logic rst;

  sma_interp_x4_if #(.DATA_W(DW)) ifc ();

  sma_interp_x4 #(.DATA_W(DW), .RATIO_LOG2(RL2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected outputs, generated a whole window at a time from accepted inputs.
  int exp_q[$];
  int got[$];
  int mdl_prev = 0;
  bit stall    = 0;
  int stall_y  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Compare process: samples on the falling edge, i.e. what the next posedge will transfer.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      mdl_prev = 0;
      stall    = 0;
    end else begin
      if (stall) begin
        chk("y_valid_hold", int'(ifc.y_valid), 1);
        chk("y_stable", int'($signed(ifc.y)), stall_y);
      end
      if (ifc.y_valid && ifc.y_ready) begin
        if (exp_q.size() == 0) begin
          chk("y_unexpected", int'($signed(ifc.y)), -99999);
        end else begin
          chk("y_model", int'($signed(ifc.y)), exp_q.pop_front());
        end
        got.push_back(int'($signed(ifc.y)));
      end
      stall   = ifc.y_valid && !ifc.y_ready;
      stall_y = int'($signed(ifc.y));
      if (ifc.x_valid && ifc.x_ready) begin
        int cur_i;
        cur_i = int'($signed(ifc.x));
        for (int k = 0; k < RAT; k++)
          exp_q.push_back(mdl_prev + (((cur_i - mdl_prev) * k) >>> RL2));
        mdl_prev = cur_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    ifc.y_ready = 1'b1;
    ifc.x_valid = 1'b0;
    while (ifc.y_valid && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", guard, 0);
  endtask

  // Feed samples back-to-back with y_ready held high, then drain.
  task automatic feed(input int vals[$]);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    ifc.y_ready = 1'b1;
    while (idx < vals.size() && guard < 1000) begin
      ifc.x       = 16'(vals[idx]);
      ifc.x_valid = 1'b1;
      if (ifc.x_ready) idx++;
      tick();
      guard++;
    end
    if (guard >= 1000) chk("feed_timeout", idx, vals.size());
    drain();
  endtask

  task automatic check_got(input string nm, input int off, input int exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (off + i < got.size()) chk(nm, got[off + i], exp[i]);
      else chk({nm, "_missing"}, got.size(), off + i + 1);
    end
  endtask

  initial begin
    int v[$];
    int e[$];
    int idx;
    int guard;

    rst         = 1'b0;
    ifc.x       = '0;
    ifc.x_valid = 1'b0;
    ifc.y_ready = 1'b0;
    #12;
    chk("rst_y_valid", int'(ifc.y_valid), 0);
    chk("rst_x_ready", int'(ifc.x_ready), 1);
    chk("rst_y", int'($signed(ifc.y)), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // First window ramps from 0; x held at 100 gives a flat second window.
    got.delete();
    ifc.x       = 16'sd100;
    ifc.x_valid = 1'b1;
    ifc.y_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      chk("x_ready_pulse", int'(ifc.x_ready), (c % 4 == 0) ? 1 : 0);
      tick();
    end
    e = {0, 25, 50, 75, 100, 100, 100, 100};
    check_got("ramp_from_reset", 0, e);
    drain();

    // Starved: idle in WAIT, then a new sample starts at the old cur.
    tick(); tick();
    chk("idle_y_valid", int'(ifc.y_valid), 0);
    chk("idle_x_ready", int'(ifc.x_ready), 1);
    got.delete();
    ifc.x       = -16'sd100;
    ifc.x_valid = 1'b1;
    tick();
    ifc.x_valid = 1'b0;
    chk("restart_y_valid", int'(ifc.y_valid), 1);
    chk("restart_y_old_cur", int'($signed(ifc.y)), 100);
    drain();
    e = {100, 50, 0, -50};
    check_got("down_ramp", 0, e);

    // Floor rounding on a tiny negative step.
    got.delete();
    v = {0, -1};
    feed(v);
    e = {0, -1, -1, -1};
    check_got("floor_round", 4, e);

    // Full-scale swings: (65535*2)>>>2 = 32767 and (-65535*2)>>>2 = -32768, so both midpoints land at -1.
    got.delete();
    v = {-32768, 32767, -32768};
    feed(v);
    e = {-32768, -16385, -1, 16383, 32767, 16383, -1, -16385};
    check_got("extremes", 4, e);

    // Random backpressure on both sides; the compare process does the checking.
    v.delete();
    for (int i = 0; i < 16; i++) v.push_back(int'($signed(16'($urandom_range(0, 65535)))));
    idx = 0;
    guard = 0;
    while (idx < v.size() && guard < 2000) begin
      ifc.y_ready = 1'($urandom_range(0, 1));
      ifc.x_valid = ($urandom_range(0, 3) != 0);
      ifc.x       = 16'(v[idx]);
      if (ifc.x_valid && ifc.x_ready) idx++;
      tick();
      guard++;
    end
    chk("rand_all_accepted", idx, v.size());
    drain();
    chk("rand_queue_empty", exp_q.size(), 0);

    // Reset mid-window at k=2.
    ifc.x       = 16'sd80;
    ifc.x_valid = 1'b1;
    ifc.y_ready = 1'b1;
    tick();
    ifc.x_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("midrst_y_valid", int'(ifc.y_valid), 0);
    chk("midrst_y", int'($signed(ifc.y)), 0);
    chk("midrst_x_ready", int'(ifc.x_ready), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    got.delete();
    v = {40};
    feed(v);
    e = {0, 10, 20, 30};
    check_got("after_reset", 0, e);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
